// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-port ALU arbiter.
// Holds the ALU select codes, port indices and arbitration modes.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    // ALU select encoding; codes not listed here pass in1 through
    localparam logic [SEL_W-1:0] ALU_SEL_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] ALU_SEL_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] ALU_SEL_SLL  = 4'd2;
    localparam logic [SEL_W-1:0] ALU_SEL_SLT  = 4'd3;
    localparam logic [SEL_W-1:0] ALU_SEL_SLTU = 4'd4;
    localparam logic [SEL_W-1:0] ALU_SEL_XOR  = 4'd5;
    localparam logic [SEL_W-1:0] ALU_SEL_SRL  = 4'd6;
    localparam logic [SEL_W-1:0] ALU_SEL_SRA  = 4'd7;
    localparam logic [SEL_W-1:0] ALU_SEL_OR   = 4'd8;
    localparam logic [SEL_W-1:0] ALU_SEL_AND  = 4'd9;

    localparam logic ARB_PORT0 = 1'b0;
    localparam logic ARB_PORT1 = 1'b1;

    localparam bit ARB_RR    = 1'b0;
    localparam bit ARB_FIXED = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [SEL_W-1:0]  sel;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the arbiter ports.
// Shift amounts use the low five bits of in2.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    logic [4:0] shamt;
    assign shamt = in2[4:0];

    always_comb begin
        out = in1;
        case (sel)
            ALU_SEL_ADD:  out = in1 + in2;
            ALU_SEL_SUB:  out = in1 - in2;
            ALU_SEL_SLL:  out = in1 << shamt;
            ALU_SEL_SLT:  out = {31'd0, $signed(in1) < $signed(in2)};
            ALU_SEL_SLTU: out = {31'd0, in1 < in2};
            ALU_SEL_XOR:  out = in1 ^ in2;
            ALU_SEL_SRL:  out = in1 >> shamt;
            ALU_SEL_SRA:  out = $unsigned($signed(in1) >>> shamt);
            ALU_SEL_OR:   out = in1 | in2;
            ALU_SEL_AND:  out = in1 & in2;
            default:      out = in1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; one grant per cycle, round-robin or port-0 priority.
// Each port owns a response register that holds its result until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit PRIO_REQ0 = ARB_RR
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready
);

    alu_req_t [1:0]          req;
    logic     [1:0]          req_valid;
    logic     [1:0]          rsp_ready_vec;
    logic     [1:0]          elig;
    logic     [1:0]          grant;
    logic     [1:0]          rsp_valid_reg;
    logic     [1:0]          rsp_valid_next;
    logic     [1:0][DATA_W-1:0] rsp_data_reg;
    logic     [1:0][DATA_W-1:0] rsp_data_next;
    logic                    last_grant_reg;
    logic                    last_grant_next;
    logic                    mux_idx;
    logic     [DATA_W-1:0]   alu_out;

    assign req[0]           = '{in1: req0_in1, in2: req0_in2, sel: req0_sel};
    assign req[1]           = '{in1: req1_in1, in2: req1_in2, sel: req1_sel};
    assign req_valid        = {req1_valid, req0_valid};
    assign rsp_ready_vec    = {rsp1_ready, rsp0_ready};

    // A full response register can still accept if it drains this cycle
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign elig[gi] = req_valid[gi] && (!rsp_valid_reg[gi] || rsp_ready_vec[gi]);

            always_comb begin
                rsp_valid_next[gi] = rsp_valid_reg[gi];
                rsp_data_next[gi]  = rsp_data_reg[gi];
                if (grant[gi]) begin
                    rsp_valid_next[gi] = 1'b1;
                    rsp_data_next[gi]  = alu_out;
                end else if (rsp_ready_vec[gi]) begin
                    rsp_valid_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (elig == 2'b11) begin
                if (PRIO_REQ0 == ARB_FIXED || last_grant_reg == ARB_PORT1) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end else begin
                grant = elig;
            end
        end
    end

    // With no grant the mux idles on port 0 and the ALU result is dropped
    assign mux_idx         = grant[1];
    assign last_grant_next = (|grant) ? grant[1] : last_grant_reg;

    alu u_alu (
        .in1 (req[mux_idx].in1),
        .in2 (req[mux_idx].in2),
        .sel (req[mux_idx].sel),
        .out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg  <= 2'b00;
            rsp_data_reg   <= '0;
            last_grant_reg <= ARB_PORT1;
        end else begin
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp1_data  = rsp_data_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a behavioural model, plus directed scenarios.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp0_ready, rsp1_ready;

    // index 0 = round-robin instance, 1 = fixed-priority instance
    logic [1:0]       q0_ready, q1_ready, r0_valid, r1_valid;
    logic [1:0][31:0] r0_data, r1_data;

    alu_arbiter #(.PRIO_REQ0(ARB_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(q0_ready[0]),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(q1_ready[0]),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_sel(req1_sel),
        .rsp0_valid(r0_valid[0]), .rsp0_data(r0_data[0]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(r1_valid[0]), .rsp1_data(r1_data[0]), .rsp1_ready(rsp1_ready)
    );

    alu_arbiter #(.PRIO_REQ0(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(q0_ready[1]),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(q1_ready[1]),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_sel(req1_sel),
        .rsp0_valid(r0_valid[1]), .rsp0_data(r0_data[1]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(r1_valid[1]), .rsp1_data(r1_data[1]), .rsp1_ready(rsp1_ready)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // model state per instance and per port
    bit          m_valid [2][2];
    logic [31:0] m_data  [2][2];
    int          m_last  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        int sh;
        sh = int'(b % 32);
        case (s)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return a;
        endcase
    endfunction

    // -1 = no grant, else index of the port that wins this cycle
    function automatic int ref_grant(input int m);
        bit e0, e1;
        if (!rst_n) return -1;
        e0 = req0_valid && (!m_valid[m][0] || rsp0_ready);
        e1 = req1_valid && (!m_valid[m][1] || rsp1_ready);
        if (e0 && e1) return (m == 1) ? 0 : 1 - m_last[m];
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        logic [31:0] res;
        bit rdy [2];
        rdy[0] = rsp0_ready;
        rdy[1] = rsp1_ready;
        for (int m = 0; m < 2; m++) begin
            g = ref_grant(m);
            res = (g == 1) ? ref_alu(req1_in1, req1_in2, req1_sel)
                           : ref_alu(req0_in1, req0_in2, req0_sel);
            if (!rst_n) begin
                for (int p = 0; p < 2; p++) begin
                    m_valid[m][p] = 0;
                    m_data[m][p]  = 32'd0;
                end
                m_last[m] = 1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (g == p) begin
                        m_valid[m][p] = 1;
                        m_data[m][p]  = res;
                    end else if (rdy[p]) begin
                        m_valid[m][p] = 0;
                    end
                end
                if (g >= 0) m_last[m] = g;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d_req0_ready", m), {31'd0, q0_ready[m]}, {31'd0, ref_grant(m) == 0});
                chk($sformatf("m%0d_req1_ready", m), {31'd0, q1_ready[m]}, {31'd0, ref_grant(m) == 1});
                chk($sformatf("m%0d_rsp0_valid", m), {31'd0, r0_valid[m]}, {31'd0, m_valid[m][0]});
                chk($sformatf("m%0d_rsp1_valid", m), {31'd0, r1_valid[m]}, {31'd0, m_valid[m][1]});
                chk($sformatf("m%0d_rsp0_data", m), r0_data[m], m_data[m][0]);
                chk($sformatf("m%0d_rsp1_data", m), r1_data[m], m_data[m][1]);
            end
        end
    end

    task automatic set_req(input int p, input bit v, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_sel = s; req0_in1 = a; req0_in2 = b;
        end else begin
            req1_valid = v; req1_sel = s; req1_in1 = a; req1_in2 = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(0, 1, ALU_SEL_ADD, 32'd1, 32'd1);
        set_req(1, 1, ALU_SEL_ADD, 32'd2, 32'd2);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        cycle();
        chk_en = 1;
        chk("reset_req0_ready", {31'd0, q0_ready[0]}, 32'd0);
        chk("reset_req1_ready", {31'd0, q1_ready[0]}, 32'd0);
        cycle();
        chk("reset_rsp0_valid", {31'd0, r0_valid[0]}, 32'd0);
        chk("reset_rsp1_data", r1_data[0], 32'd0);
        rst_n = 1'b1;

        // port 0 alone: ADD 5+7
        set_req(1, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        set_req(0, 1, ALU_SEL_ADD, 32'd5, 32'd7);
        #1;
        chk("add_req0_ready", {31'd0, q0_ready[0]}, 32'd1);
        chk("add_req1_ready", {31'd0, q1_ready[0]}, 32'd0);
        cycle();
        set_req(0, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        #1;
        chk("add_rsp0_valid", {31'd0, r0_valid[0]}, 32'd1);
        chk("add_rsp0_data", r0_data[0], 32'd12);
        chk("add_model_data", m_data[0][0], 32'd12);
        $display("txn add: rsp0_data=%0d", r0_data[0]);
        cycle();

        // both streaming, round-robin vs fixed
        do_reset();
        set_req(0, 1, ALU_SEL_SUB, 32'd10, 32'd3);
        set_req(1, 1, ALU_SEL_SRA, 32'h8000_0000, 32'd4);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_grant0_k%0d", k), {31'd0, q0_ready[0]}, {31'd0, (k % 2) == 0});
            chk($sformatf("rr_grant1_k%0d", k), {31'd0, q1_ready[0]}, {31'd0, (k % 2) == 1});
            chk($sformatf("fx_grant1_k%0d", k), {31'd0, q1_ready[1]}, 32'd0);
            $display("txn stream k=%0d rr_grant=%0d%0d fx_grant=%0d%0d", k,
                     q1_ready[0], q0_ready[0], q1_ready[1], q0_ready[1]);
            cycle();
        end
        set_req(0, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        set_req(1, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        #1;
        chk("rr_sub_data", r0_data[0], 32'd7);
        chk("rr_sra_data", r1_data[0], 32'hF800_0000);
        chk("fx_rsp1_valid", {31'd0, r1_valid[1]}, 32'd0);
        chk("fx_sub_data", r0_data[1], 32'd7);
        cycle();

        // backpressure on port 1
        set_req(1, 1, ALU_SEL_SLTU, 32'd1, 32'd2);
        rsp1_ready = 1'b0;
        #1;
        chk("bp_req1_ready", {31'd0, q1_ready[0]}, 32'd1);
        cycle();
        set_req(1, 1, ALU_SEL_ADD, 32'd1, 32'd1);
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1, ALU_SEL_ADD, 32'd3, 32'(k));
            #1;
            chk($sformatf("bp_req1_blocked_k%0d", k), {31'd0, q1_ready[0]}, 32'd0);
            chk($sformatf("bp_req0_granted_k%0d", k), {31'd0, q0_ready[0]}, 32'd1);
            chk($sformatf("bp_rsp1_valid_k%0d", k), {31'd0, r1_valid[0]}, 32'd1);
            chk($sformatf("bp_rsp1_data_k%0d", k), r1_data[0], 32'd1);
            $display("txn backpressure k=%0d rsp1_data=%0d", k, r1_data[0]);
            cycle();
        end

        // consume and reload port 0 in one cycle
        set_req(1, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        set_req(0, 1, ALU_SEL_XOR, 32'hF0, 32'hFF);
        rsp0_ready = 1'b1;
        #1;
        chk("reload_rsp0_valid_before", {31'd0, r0_valid[0]}, 32'd1);
        chk("reload_req0_ready", {31'd0, q0_ready[0]}, 32'd1);
        cycle();
        set_req(0, 0, ALU_SEL_ADD, 32'd0, 32'd0);
        rsp0_ready = 1'b0;
        #1;
        chk("reload_rsp0_valid", {31'd0, r0_valid[0]}, 32'd1);
        chk("reload_rsp0_data", r0_data[0], 32'h0F);
        $display("txn reload: rsp0_data=%h", r0_data[0]);

        // reset while port 1 holds a result
        chk("midrst_rsp1_valid_before", {31'd0, r1_valid[0]}, 32'd1);
        set_req(0, 1, ALU_SEL_ADD, 32'd9, 32'd9);
        set_req(1, 1, ALU_SEL_ADD, 32'd8, 32'd8);
        rst_n = 1'b0;
        #1;
        chk("midrst_req0_ready", {31'd0, q0_ready[0]}, 32'd0);
        chk("midrst_req1_ready", {31'd0, q1_ready[0]}, 32'd0);
        cycle();
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("midrst_rsp1_valid", {31'd0, r1_valid[0]}, 32'd0);
        chk("midrst_rsp1_data", r1_data[0], 32'd0);
        chk("midrst_first_req0", {31'd0, q0_ready[0]}, 32'd1);
        chk("midrst_first_req1", {31'd0, q1_ready[0]}, 32'd0);
        $display("txn midreset: rsp1_valid=%0d", r1_valid[0]);
        cycle();

        // randomized traffic, occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_in1   = $urandom;
            req0_in2   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            req1_in1   = $urandom;
            req1_in2   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            req0_sel   = 4'($urandom_range(0, 15));
            req1_sel   = 4'($urandom_range(0, 15));
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
